// File: rtl/vpu_wb_unit.sv
// Vector writeback unit: tracks one in-flight exec op and buffers its result
// in a first-word-fall-through FIFO that drains into the vector register file.
module vpu_wb_unit #(
    parameter int VLANE_CNT       = 4,
    parameter int OPERAND_WIDTH   = 32,
    parameter int VREG_ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 issue_i,
    output logic                                 issue_ready_o,
    input  logic [VREG_ADDR_WIDTH-1:0]           dst_addr_i,
    input  logic                                 wb_en_i,
    input  logic                                 exec_done_i,
    input  logic [OPERAND_WIDTH*VLANE_CNT-1:0]   exec_dout_i,
    output logic                                 wr_valid_o,
    input  logic                                 wr_ready_i,
    output logic [VREG_ADDR_WIDTH-1:0]           wr_addr_o,
    output logic [OPERAND_WIDTH*VLANE_CNT-1:0]   wr_data_o,
    output logic                                 busy_o,
    output logic [1:0]                           dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; wr_valid_o is never dropped and the head never changes until
    // the VRF takes it, and issue_i only counts when issue_ready_o is high.

    localparam int DATA_W = OPERAND_WIDTH * VLANE_CNT;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t                     state, state_nxt;
    logic [VREG_ADDR_WIDTH-1:0] lat_addr;
    logic                       lat_wb_en;
    logic                       accept;
    logic                       push;
    logic                       pop;

    logic [VREG_ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]          mem_data [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ARM always lasts one cycle: exec_done_i is still the previous op's level.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_ARM;
            S_ARM:   state_nxt = S_WAIT;
            S_WAIT:  if (exec_done_i) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        issue_ready_o = (state == S_IDLE) && (count < DEPTH_C);
        accept        = issue_i && issue_ready_o;
        push          = (state == S_WAIT) && exec_done_i && lat_wb_en;
        busy_o        = (state != S_IDLE) || (count != '0);
    end

    assign pop        = (count != '0) && wr_ready_i;
    assign wr_valid_o = (count != '0);
    assign wr_addr_o  = mem_addr[rd_ptr];
    assign wr_data_o  = mem_data[rd_ptr];
    assign dbg_state  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_addr  <= '0;
            lat_wb_en <= 1'b0;
        end else if (accept) begin
            lat_addr  <= dst_addr_i;
            lat_wb_en <= wb_en_i;
        end
    end

    // Only one op is in flight and issue needs a free slot, so push never overflows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_addr[i] <= '0;
                mem_data[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_addr[wr_ptr] <= lat_addr;
                mem_data[wr_ptr] <= exec_dout_i;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_vpu_wb_unit.sv
// Self-checking bench for vpu_wb_unit: directed scenarios plus random ops,
// compared every cycle against a queue-based model of the writeback stream.
module tb_vpu_wb_unit;

    localparam int VL = 4;
    localparam int OW = 32;
    localparam int AW = 5;
    localparam int FD = 4;
    localparam int DW = OW * VL;
    localparam int EW = AW + DW;

    logic          clk;
    logic          rst_n;
    logic          issue_i;
    logic          issue_ready_o;
    logic [AW-1:0] dst_addr_i;
    logic          wb_en_i;
    logic          exec_done_i;
    logic [DW-1:0] exec_dout_i;
    logic          wr_valid_o;
    logic          wr_ready_i;
    logic [AW-1:0] wr_addr_o;
    logic [DW-1:0] wr_data_o;
    logic          busy_o;
    logic [1:0]    dbg_state;

    vpu_wb_unit #(
        .VLANE_CNT(VL), .OPERAND_WIDTH(OW), .VREG_ADDR_WIDTH(AW), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .issue_i(issue_i), .issue_ready_o(issue_ready_o),
        .dst_addr_i(dst_addr_i), .wb_en_i(wb_en_i), .exec_done_i(exec_done_i),
        .exec_dout_i(exec_dout_i), .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i),
        .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .busy_o(busy_o),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: pending writes in order, plus whether an op is outstanding and how
    // many edges have passed since it was issued.
    logic [EW-1:0] exp_q[$];
    bit            m_inflight = 1'b0;
    int            m_age      = 0;
    logic [AW-1:0] m_addr     = '0;
    bit            m_wb       = 1'b0;
    bit            rand_ready = 1'b0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic bit model_ready();
        return !m_inflight && (exp_q.size() < FD);
    endfunction

    task automatic check_all();
        chk("issue_ready", DW'(issue_ready_o), DW'(model_ready()));
        chk("wr_valid", DW'(wr_valid_o), DW'(exp_q.size() != 0));
        chk("busy", DW'(busy_o), DW'(m_inflight || exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("wr_addr", DW'(wr_addr_o), DW'(exp_q[0][EW-1 -: AW]));
            chk("wr_data", wr_data_o, exp_q[0][DW-1:0]);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_issue_ready", DW'(issue_ready_o), DW'(1'b1));
        chk("rst_wr_valid", DW'(wr_valid_o), DW'(1'b0));
        chk("rst_wr_addr", DW'(wr_addr_o), '0);
        chk("rst_wr_data", wr_data_o, '0);
        chk("rst_busy", DW'(busy_o), DW'(1'b0));
    endtask

    // Checks outputs mid-cycle, advances the model across the next rising edge.
    task automatic cycle();
        bit do_pop;
        bit do_push;
        @(negedge clk);
        check_all();
        do_pop  = rst_n && exp_q.size() != 0 && wr_ready_i;
        do_push = rst_n && m_inflight && m_age >= 2 && exec_done_i && m_wb;
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back({m_addr, exec_dout_i});
        if (rst_n) begin
            if (m_inflight) begin
                if (m_age >= 2 && exec_done_i) m_inflight = 1'b0;
                else m_age++;
            end else if (issue_i && (exp_q.size() - int'(do_push) + int'(do_pop)) < FD) begin
                m_inflight = 1'b1;
                m_age      = 1;
                m_addr     = dst_addr_i;
                m_wb       = wb_en_i;
            end
        end
        @(posedge clk);
        #1;
        if (rand_ready) wr_ready_i = 1'($urandom_range(0, 1));
    endtask

    task automatic issue_op(input logic [AW-1:0] addr, input bit wb, input logic [DW-1:0] data,
                            input int delay, input bit stale);
        int guard;
        guard = 0;
        while (!model_ready() && guard < 200) begin
            cycle();
            guard++;
        end
        if (guard >= 200) chk("issue_wait_timeout", DW'(guard), DW'(0));
        dst_addr_i = addr;
        wb_en_i    = wb;
        issue_i    = 1'b1;
        if (stale) begin
            exec_done_i = 1'b1;
            exec_dout_i = data;
        end else begin
            exec_done_i = 1'b0;
            exec_dout_i = {$urandom, $urandom, $urandom, $urandom};
        end
        cycle();
        issue_i    = 1'b0;
        dst_addr_i = AW'($urandom);
        wb_en_i    = 1'($urandom);
        repeat (delay) cycle();
        exec_done_i = 1'b1;
        exec_dout_i = data;
        guard = 0;
        while (m_inflight && guard < 50) begin
            cycle();
            guard++;
        end
        if (guard >= 50) chk("op_done_timeout", DW'(guard), DW'(0));
    endtask

    task automatic drain(input int bound);
        int g;
        g = 0;
        while ((exp_q.size() != 0 || m_inflight) && g < bound) begin
            cycle();
            g++;
        end
        chk("drain_empty", DW'(exp_q.size()), DW'(0));
    endtask

    function automatic logic [DW-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        rst_n       = 1'b0;
        issue_i     = 1'b0;
        dst_addr_i  = '0;
        wb_en_i     = 1'b0;
        exec_done_i = 1'b1;
        exec_dout_i = '0;
        wr_ready_i  = 1'b1;
        #3;
        check_reset_outputs();
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();

        // Single op, done well after ARM, VRF always ready.
        issue_op(5'd3, 1'b1, {VL{32'hA5A5_A5A5}}, 3, 1'b0);
        drain(20);
        chk("single_busy_low", DW'(busy_o), DW'(1'b0));

        // Done still high from the previous op while issuing.
        issue_op(5'd9, 1'b1, rand_data(), 0, 1'b1);
        drain(20);

        // Discarded result never reaches the VRF.
        issue_op(5'd12, 1'b0, rand_data(), 1, 1'b0);
        repeat (4) cycle();

        // Fill the buffer under backpressure, try a fifth issue, then drain.
        wr_ready_i = 1'b0;
        for (int i = 1; i <= 4; i++) issue_op(AW'(i), 1'b1, rand_data(), i - 1, 1'b0);
        repeat (2) cycle();
        chk("full_issue_ready", DW'(issue_ready_o), DW'(1'b0));
        dst_addr_i = 5'd5;
        wb_en_i    = 1'b1;
        issue_i    = 1'b1;
        repeat (3) cycle();
        issue_i    = 1'b0;
        wr_ready_i = 1'b1;
        drain(30);
        repeat (2) cycle();

        // Push and pop on the same edge with two entries buffered.
        wr_ready_i = 1'b0;
        issue_op(5'd20, 1'b1, rand_data(), 0, 1'b0);
        issue_op(5'd21, 1'b1, rand_data(), 2, 1'b0);
        dst_addr_i  = 5'd22;
        wb_en_i     = 1'b1;
        exec_done_i = 1'b0;
        issue_i     = 1'b1;
        cycle();
        issue_i = 1'b0;
        cycle();
        exec_done_i = 1'b1;
        exec_dout_i = rand_data();
        wr_ready_i  = 1'b1;
        cycle();
        wr_ready_i = 1'b0;
        repeat (2) cycle();
        chk("simul_head_addr", DW'(wr_addr_o), DW'(5'd21));
        wr_ready_i = 1'b1;
        drain(20);

        // Reset while an op waits and two results are buffered.
        wr_ready_i = 1'b0;
        issue_op(5'd7, 1'b1, rand_data(), 0, 1'b0);
        issue_op(5'd8, 1'b1, rand_data(), 1, 1'b0);
        dst_addr_i  = 5'd9;
        wb_en_i     = 1'b1;
        exec_done_i = 1'b0;
        issue_i     = 1'b1;
        cycle();
        issue_i = 1'b0;
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        m_inflight = 1'b0;
        cycle();
        rst_n       = 1'b1;
        wr_ready_i  = 1'b1;
        exec_done_i = 1'b1;
        repeat (8) cycle();

        // Random ops with random backpressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            issue_op(AW'($urandom), $urandom_range(0, 3) != 0, rand_data(),
                     $urandom_range(0, 4), $urandom_range(0, 3) == 0);
        end
        drain(300);
        rand_ready = 1'b0;
        wr_ready_i = 1'b1;
        drain(20);
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vpu_wb_unit.md
VPU_WB_UNIT -- requirements
Module: VPU_WB_UNIT

Interface
REQ-001 SHALL have parameter VLANE_CNT, default 4: number of vector lanes.
REQ-002 SHALL have parameter OPERAND_WIDTH, default 32: bits per lane.
REQ-003 SHALL have parameter VREG_ADDR_WIDTH, default 5: destination vector-register address width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4 (power of 2, >=2): writeback buffer entries.
REQ-005 SHALL have port clk, input, 1: single clock, all logic rising-edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port issue_i, input, 1: op issued to exec unit this cycle (same pulse as exec start).
REQ-008 SHALL have port issue_ready_o, output, 1: block can accept an issue.
REQ-009 SHALL have port dst_addr_i, input, VREG_ADDR_WIDTH: destination register, valid with issue_i.
REQ-010 SHALL have port wb_en_i, input, 1: result is written back (0 = discard), valid with issue_i.
REQ-011 SHALL have port exec_done_i, input, 1: exec unit done level (high while idle/finished).
REQ-012 SHALL have port exec_dout_i, input, OPERAND_WIDTH*VLANE_CNT: exec result, valid when exec_done_i=1.
REQ-013 SHALL have port wr_valid_o, output, 1: write request to VRF.
REQ-014 SHALL have port wr_ready_i, input, 1: VRF accepts write.
REQ-015 SHALL have port wr_addr_o, output, VREG_ADDR_WIDTH: write address.
REQ-016 SHALL have port wr_data_o, output, OPERAND_WIDTH*VLANE_CNT: write data.
REQ-017 SHALL have port busy_o, output, 1: op in flight or FIFO non-empty.

Function
REQ-018 SHALL implement FSM IDLE, ARM, WAIT; reset state IDLE.
REQ-019 IDLE: issue_ready_o = (fifo_count < FIFO_DEPTH); issue_i with issue_ready_o=1 latches dst_addr_i, wb_en_i and moves to ARM.
REQ-020 issue_i while issue_ready_o=0 SHALL be ignored (no state or latch change).
REQ-021 ARM: exec_done_i ignored (exec counter reloading); unconditionally moves to WAIT next cycle.
REQ-022 WAIT: when exec_done_i=1, SHALL push {latched addr, exec_dout_i} into FIFO if latched wb_en=1, else discard; move to IDLE same edge.
REQ-023 issue_ready_o SHALL be 0 in ARM and WAIT (one op in flight max); hence FIFO never overflows.
REQ-024 FIFO SHALL be first-word-fall-through: wr_valid_o = non-empty; wr_addr_o/wr_data_o = head entry, held stable while wr_valid_o=1 and wr_ready_i=0.
REQ-025 Pop SHALL occur on wr_valid_o & wr_ready_i; simultaneous push and pop SHALL keep count unchanged, order preserved.
REQ-026 Read/write pointers SHALL wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
REQ-027 Minimum latency: issue at cycle t, exec_done_i high at t+2 -> wr_valid_o high at t+3.
REQ-028 Issue accepted in IDLE on the same edge a push completes SHALL be permitted (back-to-back ops).
REQ-029 busy_o = (state != IDLE) | (fifo_count != 0).
REQ-030 wr_data_o SHALL be lane-ordered unchanged: lane k at bits [k*OPERAND_WIDTH +: OPERAND_WIDTH].

Reset
REQ-031 rst_n=0 SHALL asynchronously force state IDLE, pointers and count 0, latched addr/wb_en 0.
REQ-032 Reset outputs: issue_ready_o=1, wr_valid_o=0, wr_addr_o=0, wr_data_o=0 (storage cleared), busy_o=0.
REQ-033 Reset mid-operation SHALL drop the in-flight op and all buffered entries; no write emitted after release.

Verification
REQ-034 Issue dst=3, wb_en=1, done at t+4 with dout=0x...A5 per lane, wr_ready_i=1 -> one write addr 3, data matches, busy_o low after pop.
REQ-035 exec_done_i held 1 through issue (stale done) -> no push in ARM; push only on first WAIT cycle at t+2.
REQ-036 wb_en=0 issue -> FSM returns IDLE, wr_valid_o never asserts.
REQ-037 wr_ready_i=0, four ops dst 1..4 -> count 4, issue_ready_o=0, 5th issue ignored; release ready -> writes 1,2,3,4 in order, data stable while stalled.
REQ-038 Push and pop same cycle with count=2 -> count stays 2, order preserved.
REQ-039 rst_n low while in WAIT with 2 buffered entries -> all outputs at reset values immediately, no writes after release.
